// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak sponge controller: mode encodings, rate and
// domain tables, FSM state codes and the word-to-lane slice mapping.
package keccak_pkg;

    localparam int BW_DATA = 1600;
    localparam int BW_WORD = 64;
    localparam int BW_OLEN = 16;

    typedef enum logic [1:0] {
        MODE_SHA3_256 = 2'd0,
        MODE_SHA3_512 = 2'd1,
        MODE_SHAKE128 = 2'd2,
        MODE_SHAKE256 = 2'd3
    } mode_e;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_ABSORB  = 3'd1;
    localparam state_t ST_PAD     = 3'd2;
    localparam state_t ST_PERM    = 3'd3;
    localparam state_t ST_SQUEEZE = 3'd4;

    function automatic logic [4:0] rate_lanes(input mode_e m);
        case (m)
            MODE_SHA3_256: return 5'd17;
            MODE_SHA3_512: return 5'd9;
            MODE_SHAKE128: return 5'd21;
            default:       return 5'd17;
        endcase
    endfunction

    function automatic logic [7:0] domain_byte(input mode_e m);
        case (m)
            MODE_SHA3_256, MODE_SHA3_512: return 8'h06;
            default:                      return 8'h1F;
        endcase
    endfunction

    // Word i sits in lane x=i%5, y=i/5, stored MSB-first at slot 5x+y.
    function automatic logic [10:0] lane_lsb(input logic [4:0] idx);
        logic [4:0] x;
        logic [4:0] y;
        logic [4:0] l;
        x = idx % 5'd5;
        y = idx / 5'd5;
        l = x * 5'd5 + y;
        return 11'd1536 - {l, 6'd0};
    endfunction

endpackage

// File: rtl/keccak_pad_mask.sv
// Combinational pad10*1 mask: domain byte at (word, byte) plus 0x80 in the top
// byte of the last rate lane; the two XOR together when they coincide.
module keccak_pad_mask
    import keccak_pkg::*;
(
    input  mode_e              mode_i,
    input  logic [4:0]         wc_i,
    input  logic [2:0]         nbytes_i,
    output logic [BW_DATA-1:0] mask_o
);

    logic [4:0]  rate;
    logic [10:0] dom_pos;
    logic [10:0] end_pos;

    assign rate    = rate_lanes(mode_i);
    assign dom_pos = lane_lsb(wc_i) + {5'd0, nbytes_i, 3'd0};
    assign end_pos = lane_lsb(rate - 5'd1) + 11'd56;

    always_comb begin
        mask_o = '0;
        if (wc_i < rate) begin
            mask_o[dom_pos +: 8] = domain_byte(mode_i);
        end
        mask_o[end_pos +: 8] = mask_o[end_pos +: 8] ^ 8'h80;
    end

endmodule

// File: rtl/keccak_sponge_ctrl.sv
// Sponge controller for SHA3-256/512 and SHAKE128/256: absorbs 64-bit words,
// pads, hands the state to an external Keccak-f core and squeezes output words.
module keccak_sponge_ctrl
    import keccak_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [1:0]         i_mode,
    input  logic [BW_OLEN-1:0] i_olen,
    input  logic [BW_WORD-1:0] i_din,
    input  logic               i_din_valid,
    input  logic               i_din_last,
    input  logic [3:0]         i_din_nbytes,
    output logic               o_din_ready,
    output logic [BW_DATA-1:0] o_perm_lanes,
    output logic               o_perm_valid,
    input  logic [BW_DATA-1:0] i_perm_lanes,
    input  logic               i_perm_valid,
    output logic [BW_WORD-1:0] o_dout,
    output logic               o_dout_valid,
    input  logic               i_dout_ready,
    output logic               o_busy,
    output logic               o_done
);

    // Streams use valid/ready: a word moves on a rising edge where both are high;
    // the producer holds data stable while valid is high and ready is low.

    state_t             fsm_q, fsm_d;
    state_t             ret_q, ret_d;
    mode_e              mode_q, mode_d;
    logic [BW_DATA-1:0] st_q, st_d;
    logic [4:0]         wc_q, wc_d;
    logic [2:0]         nb_q, nb_d;
    logic [BW_OLEN-1:0] rem_q, rem_d;
    logic               req_q, req_d;
    logic               done_q, done_d;

    logic [4:0]         rate;
    logic [BW_WORD-1:0] din_mask;
    logic [BW_DATA-1:0] pad_mask;
    logic [10:0]        wc_lsb;

    assign rate   = rate_lanes(mode_q);
    assign wc_lsb = lane_lsb(wc_q);

    keccak_pad_mask u_pad_mask (
        .mode_i   (mode_q),
        .wc_i     (wc_q),
        .nbytes_i (nb_q),
        .mask_o   (pad_mask)
    );

    always_comb begin
        din_mask = '0;
        for (int b = 0; b < 8; b++) begin
            din_mask[8*b +: 8] = (!i_din_last || i_din_nbytes > 4'(b)) ? 8'hFF : 8'h00;
        end
    end

    always_comb begin
        fsm_d  = fsm_q;
        ret_d  = ret_q;
        mode_d = mode_q;
        st_d   = st_q;
        wc_d   = wc_q;
        nb_d   = nb_q;
        rem_d  = rem_q;
        req_d  = 1'b0;
        done_d = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (i_start) begin
                    mode_d = mode_e'(i_mode);
                    case (mode_e'(i_mode))
                        MODE_SHA3_256: rem_d = BW_OLEN'(4);
                        MODE_SHA3_512: rem_d = BW_OLEN'(8);
                        default:       rem_d = i_olen;
                    endcase
                    st_d  = '0;
                    wc_d  = '0;
                    nb_d  = '0;
                    fsm_d = ST_ABSORB;
                end
            end
            ST_ABSORB: begin
                if (i_din_valid) begin
                    st_d[wc_lsb +: BW_WORD] = st_q[wc_lsb +: BW_WORD] ^ (i_din & din_mask);
                    if (i_din_last) begin
                        // A full last word pushes the pad into the next word slot.
                        if (i_din_nbytes >= 4'd8) begin
                            wc_d = wc_q + 5'd1;
                            nb_d = '0;
                        end else begin
                            nb_d = i_din_nbytes[2:0];
                        end
                        fsm_d = ST_PAD;
                    end else if (wc_q + 5'd1 == rate) begin
                        wc_d  = '0;
                        ret_d = ST_ABSORB;
                        req_d = 1'b1;
                        fsm_d = ST_PERM;
                    end else begin
                        wc_d = wc_q + 5'd1;
                    end
                end
            end
            ST_PAD: begin
                if (wc_q == rate) begin
                    wc_d  = '0;
                    nb_d  = '0;
                    ret_d = ST_PAD;
                end else begin
                    st_d  = st_q ^ pad_mask;
                    wc_d  = '0;
                    ret_d = ST_SQUEEZE;
                end
                req_d = 1'b1;
                fsm_d = ST_PERM;
            end
            ST_PERM: begin
                if (i_perm_valid) begin
                    st_d = i_perm_lanes;
                    if (ret_q == ST_SQUEEZE && rem_q == '0) begin
                        done_d = 1'b1;
                        fsm_d  = ST_IDLE;
                    end else begin
                        fsm_d = ret_q;
                    end
                end
            end
            ST_SQUEEZE: begin
                if (i_dout_ready) begin
                    rem_d = rem_q - BW_OLEN'(1);
                    if (rem_q == BW_OLEN'(1)) begin
                        wc_d   = '0;
                        done_d = 1'b1;
                        fsm_d  = ST_IDLE;
                    end else if (wc_q + 5'd1 == rate) begin
                        wc_d  = '0;
                        ret_d = ST_SQUEEZE;
                        req_d = 1'b1;
                        fsm_d = ST_PERM;
                    end else begin
                        wc_d = wc_q + 5'd1;
                    end
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fsm_q  <= ST_IDLE;
            ret_q  <= ST_IDLE;
            mode_q <= MODE_SHA3_256;
            st_q   <= '0;
            wc_q   <= '0;
            nb_q   <= '0;
            rem_q  <= '0;
            req_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            ret_q  <= ret_d;
            mode_q <= mode_d;
            st_q   <= st_d;
            wc_q   <= wc_d;
            nb_q   <= nb_d;
            rem_q  <= rem_d;
            req_q  <= req_d;
            done_q <= done_d;
        end
    end

    assign o_din_ready  = (fsm_q == ST_ABSORB);
    assign o_perm_lanes = st_q;
    assign o_perm_valid = req_q;
    assign o_dout_valid = (fsm_q == ST_SQUEEZE);
    assign o_dout       = o_dout_valid ? st_q[wc_lsb +: BW_WORD] : '0;
    assign o_busy       = (fsm_q != ST_IDLE);
    assign o_done       = done_q;

endmodule
